subneg_loader: RTL and testbench

SUBNEG_LOADER -- requirements
Module: subneg_loader

---
 rtl/subneg_loader.sv | 188 ++++++++++++++++++
 tb/tb_subneg_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subneg_loader.sv
// subneg_loader: streams program bytes from an upstream valid/ready source into
// the SUBNEG CPU SRAM over the shared address/data bus, then releases the CPU.
// Each byte goes through an address phase (latched by mem_latch_clk), a data
// phase and a single-cycle active-low write strobe.
// Optional read-back verify of every byte: define LOADER_VERIFY_EN.
module subneg_loader #(
  parameter logic [7:0] START_ADDR = 8'd0,
  parameter logic [7:0] END_ADDR   = 8'd254
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic [7:0] bus_oe,
  output logic       mem_latch_clk,
  output logic       mem_oe,
  output logic       mem_we,
  output logic       busy,
  output logic       done,
  output logic       cpu_run,
  output logic       verify_err
);

  localparam int unsigned DW = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_LATCH,
    S_DATA,
    S_WRITE,
    S_RELEASE,
    S_DONE
`ifdef LOADER_VERIFY_EN
    ,
    S_VREAD,
    S_VCMP
`endif
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] addr;
  logic [DW-1:0] addr_next;
  logic [DW-1:0] data;
  logic [DW-1:0] data_next;
  logic          verr_next;

  logic          in_ready_next;
  logic [DW-1:0] bus_out_next;
  logic          latch_next;
  logic          oe_next;
  logic          we_next;
  logic          busy_next;
  logic          done_next;

  // Range end: also catches START_ADDR > END_ADDR so the address never wraps.
  logic          last_addr;
  assign last_addr = (addr >= END_ADDR);

`ifndef LOADER_VERIFY_EN
  // Read path is only needed by the verify pass.
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
`endif

  // Next state, datapath updates and the output values for the state being entered.
  always_comb begin
    state_next = state;
    addr_next  = addr;
    data_next  = data;
    verr_next  = verify_err;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_WAIT;
          addr_next  = START_ADDR;
          verr_next  = 1'b0;
        end
      end
      S_WAIT: begin
        if (in_valid) begin
          data_next  = in_data;
          state_next = S_ADDR;
        end
      end
      S_ADDR:  state_next = S_LATCH;
      S_LATCH: state_next = S_DATA;
      S_DATA:  state_next = S_WRITE;
      S_WRITE: state_next = S_RELEASE;
`ifdef LOADER_VERIFY_EN
      S_RELEASE: state_next = S_VREAD;
      S_VREAD:   state_next = S_VCMP;
      S_VCMP: begin
        if (bus_in != data) begin
          verr_next = 1'b1;
        end
        if (last_addr) begin
          state_next = S_DONE;
        end else begin
          addr_next  = addr + DW'(1);
          state_next = S_WAIT;
        end
      end
`else
      S_RELEASE: begin
        if (last_addr) begin
          state_next = S_DONE;
        end else begin
          addr_next  = addr + DW'(1);
          state_next = S_WAIT;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase

    in_ready_next = (state_next == S_WAIT);
    busy_next     = (state_next != S_IDLE) && (state_next != S_DONE);
    done_next     = (state_next == S_DONE);
    we_next       = (state_next != S_WRITE);
`ifdef LOADER_VERIFY_EN
    oe_next       = (state_next != S_VREAD) && (state_next != S_VCMP);
`else
    oe_next       = 1'b1;
`endif

    // Latch clock stays high from the address latch until the byte is finished,
    // so it never moves while the write strobe is low.
    case (state_next)
      S_LATCH, S_DATA, S_WRITE, S_RELEASE: latch_next = 1'b1;
`ifdef LOADER_VERIFY_EN
      S_VREAD, S_VCMP:                     latch_next = 1'b1;
`endif
      default:                             latch_next = 1'b0;
    endcase

    bus_out_next = bus_out;
    case (state_next)
      S_ADDR, S_LATCH:             bus_out_next = addr_next;
      S_DATA, S_WRITE, S_RELEASE:  bus_out_next = data_next;
`ifdef LOADER_VERIFY_EN
      S_VREAD, S_VCMP:             bus_out_next = data_next;
`endif
      default:                     bus_out_next = bus_out;
    endcase
  end

  // State, datapath and registered outputs; reset forces a safe bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      addr          <= START_ADDR;
      data          <= '0;
      in_ready      <= 1'b0;
      bus_out       <= '0;
      bus_oe        <= '1;
      mem_latch_clk <= 1'b0;
      mem_oe        <= 1'b1;
      mem_we        <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      cpu_run       <= 1'b0;
      verify_err    <= 1'b0;
    end else begin
      state         <= state_next;
      addr          <= addr_next;
      data          <= data_next;
      in_ready      <= in_ready_next;
      bus_out       <= bus_out_next;
      bus_oe        <= {DW{oe_next}};
      mem_latch_clk <= latch_next;
      mem_oe        <= oe_next;
      mem_we        <= we_next;
      busy          <= busy_next;
      done          <= done_next;
      cpu_run       <= done_next;
      verify_err    <= verr_next;
    end
  end

endmodule

// File: tb/tb_subneg_loader.sv
// Bench for subneg_loader: a full-range instance driven through several loads
// against an SRAM model plus a write scoreboard, and two single-byte instances
// (START==END and START>END).
module tb_subneg_loader;

`ifdef LOADER_VERIFY_EN
  localparam int CPB = 8;
`else
  localparam int CPB = 6;
`endif
  localparam int LIMIT = 20000;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic [7:0] bus_oe;
  logic       mem_latch_clk;
  logic       mem_oe;
  logic       mem_we;
  logic       busy;
  logic       done;
  logic       cpu_run;
  logic       verify_err;

  // shared stimulus for the two single-byte instances
  logic       s_start;
  logic       s_valid;
  logic [7:0] s_data;
  logic [7:0] s_bus_in = 8'hA5;
  logic       a_ready, a_latch, a_oe, a_we, a_busy, a_done, a_run, a_verr;
  logic [7:0] a_bus, a_bus_oe;
  logic       b_ready, b_latch, b_oe, b_we, b_busy, b_done, b_run, b_verr;
  logic [7:0] b_bus, b_bus_oe;

  int n_total = 0;
  int n_bad   = 0;

  wr_t        exp_q[$];
  logic [7:0] sram    [0:255];
  logic [7:0] exp_mem [0:255];
  logic [7:0] lat_addr = 8'h00;
  logic       prev_we_low = 1'b0;
  logic       wrote_ff = 1'b0;
  bit         abort = 1'b0;

  int         a_cnt = 0;
  int         b_cnt = 0;
  logic [7:0] a_lat = 8'h00, a_waddr = 8'h00, a_wdata = 8'h00;
  logic [7:0] b_lat = 8'h00, b_waddr = 8'h00, b_wdata = 8'h00;

  always #5 clk = ~clk;

  subneg_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .mem_latch_clk(mem_latch_clk), .mem_oe(mem_oe), .mem_we(mem_we), .busy(busy),
    .done(done), .cpu_run(cpu_run), .verify_err(verify_err)
  );

  subneg_loader #(.START_ADDR(8'h10), .END_ADDR(8'h10)) u_one (
    .clk(clk), .reset(reset), .start(s_start), .in_data(s_data), .in_valid(s_valid),
    .in_ready(a_ready), .bus_in(s_bus_in), .bus_out(a_bus), .bus_oe(a_bus_oe),
    .mem_latch_clk(a_latch), .mem_oe(a_oe), .mem_we(a_we), .busy(a_busy),
    .done(a_done), .cpu_run(a_run), .verify_err(a_verr)
  );

  subneg_loader #(.START_ADDR(8'h20), .END_ADDR(8'h05)) u_rev (
    .clk(clk), .reset(reset), .start(s_start), .in_data(s_data), .in_valid(s_valid),
    .in_ready(b_ready), .bus_in(s_bus_in), .bus_out(b_bus), .bus_oe(b_bus_oe),
    .mem_latch_clk(b_latch), .mem_oe(b_oe), .mem_we(b_we), .busy(b_busy),
    .done(b_done), .cpu_run(b_run), .verify_err(b_verr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM model: address latch on rising latch clock, combinational read port
  always @(posedge mem_latch_clk) lat_addr = bus_out;
  assign bus_in = sram[lat_addr];

  // Write monitor: commits the byte to the SRAM model and scores it
  always @(negedge clk) begin
    wr_t e;
    if (!reset && mem_we == 1'b0) begin
      check("we_single_cycle", 32'(prev_we_low), 32'd0);
      check("oe_during_we", 32'(mem_oe), 32'd1);
      check("latch_during_we", 32'(mem_latch_clk), 32'd1);
      check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(lat_addr), 32'(e.a));
        check("wr_data", 32'(bus_out), 32'(e.d));
      end
      if (lat_addr == 8'hFF) wrote_ff = 1'b1;
      sram[lat_addr] = bus_out;
    end
    if (in_ready) check("rdy_outside_wait", 32'({mem_latch_clk, mem_we, busy}), 32'b011);
    prev_we_low = !reset && !mem_we;
  end

  // Single-byte instance monitors
  always @(posedge a_latch) a_lat = a_bus;
  always @(posedge b_latch) b_lat = b_bus;
  always @(negedge clk) begin
    if (!reset && !a_we) begin a_cnt++; a_waddr = a_lat; a_wdata = a_bus; end
    if (!reset && !b_we) begin b_cnt++; b_waddr = b_lat; b_wdata = b_bus; end
  end

  task automatic check_reset_outs(input string tag);
    check(tag, 32'({in_ready, bus_out, bus_oe, mem_latch_clk, mem_oe, mem_we, busy, done,
                    cpu_run, verify_err}),
          32'({1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
  endtask

  task automatic check_done_outs(input string tag);
    check(tag, 32'({in_ready, mem_latch_clk, mem_oe, mem_we, busy, done, cpu_run, verify_err}),
          32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}));
  endtask

  task automatic check_contents();
    for (int a = 0; a < 255; a++) check("sram_content", 32'(sram[a]), 32'(exp_mem[a]));
    check("addr_ff_untouched", 32'(wrote_ff), 32'd0);
  endtask

  // Upstream source: offers n bytes with optional random gaps, scores each accept
  task automatic send(input int n, input int gap_max, input int mode);
    int         g;
    int         t;
    bit         got;
    logic [7:0] dat;
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      case (mode)
        0:       dat = 8'(i);
        1:       dat = 8'($urandom);
        default: dat = ~8'(i);
      endcase
      in_data  = dat;
      in_valid = 1'b1;
      got = 1'b0;
      t   = 0;
      while (!got && !abort && t < 200) begin
        @(negedge clk);
        if (in_ready && !reset) begin
          exp_q.push_back('{a: 8'(i), d: dat});
          exp_mem[i] = dat;
          got = 1'b1;
        end
        @(posedge clk); #1;
        t++;
      end
      if (!abort) check("accept_timeout", 32'(got), 32'd1);
      if (!got) break;
    end
    in_valid = 1'b0;
  endtask

  // One full-range load; exp_cycles==0 skips the cycle-count comparison
  task automatic run_load(input int gap_max, input int mode, input bit noise,
                          input int exp_cycles);
    @(posedge clk); #1;
    start = 1'b1;
    fork
      send(255, gap_max, mode);
      begin
        int cyc;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < LIMIT) begin @(posedge clk); #1; cyc++; end
        check("done_reached", 32'(done), 32'd1);
        if (exp_cycles > 0) check("load_cycles", 32'(cyc), 32'(exp_cycles));
      end
      if (noise) begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        k = 0;
        while (!done && k < 3000) begin
          repeat ($urandom_range(30, 5)) @(posedge clk);
          #1;
          if (busy) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
          end
          k++;
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    int cyc;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    s_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst_init_outs");
    check("rst_init_small", 32'({a_busy, a_done, a_we, b_busy, b_done, b_we}), 32'b001001);
    reset = 1'b0;

    // Full range, in_valid held, addr==data, exact byte throughput
    run_load(0, 0, 1'b0, 255 * CPB + 1);
    check_done_outs("load0_done_outs");
    check_contents();

    // Single-byte instances: START==END and START>END
    @(posedge clk); #1;
    s_start = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 1;
    while (!(a_done && b_done) && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("one_cycles", 32'(cyc), 32'(CPB + 1));
    repeat (10) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("one_we_pulses", 32'(a_cnt), 32'd1);
    check("one_wr_addr", 32'(a_waddr), 32'h10);
    check("one_wr_data", 32'(a_wdata), 32'hA5);
    check("one_done_run", 32'({a_done, a_run, a_busy, a_ready}), 32'b1100);
    check("rev_we_pulses", 32'(b_cnt), 32'd1);
    check("rev_wr_addr", 32'(b_waddr), 32'h20);
    check("rev_wr_data", 32'(b_wdata), 32'hA5);
    check("rev_done_run", 32'({b_done, b_run, b_busy, b_ready}), 32'b1100);

    // Random gaps and data, stray start pulses while busy
    run_load(10, 1, 1'b1, 0);
    check_done_outs("load1_done_outs");
    check_contents();

    // Reset during the write strobe of byte 5
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b0;
    fork
      send(255, 0, 2);
      begin
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 6 && cyc < 500) begin
          @(posedge clk); #1;
          cyc++;
          if (!mem_we) k++;
        end
        check("mid_write_reached", 32'(k), 32'd6);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_we", 32'(mem_we), 32'd1);
        check_reset_outs("rst_mid_outs");
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    exp_q.delete();
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", 32'({busy, done, in_ready}), 32'b000);

    // Clean reload from START_ADDR
    run_load(0, 2, 1'b0, 255 * CPB + 1);
    check_done_outs("load2_done_outs");
    check_contents();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
